// File: rtl/logic_result_stage_if.sv
// Handshake bundle for the logic result stage:
// operand/op input side and buffered result/flag output side.
interface logic_result_stage_if #(
  parameter int WIDTH = 32,
  parameter int CW    = 2
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] C;
  logic             Z;
  logic             N;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    occupancy;

  modport master (
    output A, B, op, in_valid, out_ready,
    input  in_ready, C, Z, N, out_valid, occupancy
  );

  modport slave (
    input  A, B, op, in_valid, out_ready,
    output in_ready, C, Z, N, out_valid, occupancy
  );
endinterface

// File: rtl/logic_result_stage.sv
// Registered result stage for the bitwise logic unit:
// computes result+flags at accept and queues them in a small FIFO.
module logic_result_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 2
) (
  input logic clk,
  input logic rst,
  logic_result_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic             n;
    logic             z;
    logic [WIDTH-1:0] c;
  } ent_t;

  ent_t             r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_res;
  logic             w_full;
  logic             w_empty;
  logic             w_ready;
  logic             w_push;
  logic             w_pop;
  ent_t             w_head;

  always_comb begin
    w_res = '0;
    case (bus.op)
      3'b000: w_res = bus.A & bus.B;
      3'b001: w_res = ~(bus.A & bus.B);
      3'b010: w_res = bus.A | bus.B;
      3'b011: w_res = ~(bus.A | bus.B);
      3'b100: w_res = bus.A ^ bus.B;
      3'b101: w_res = ~(bus.A ^ bus.B);
      3'b110: w_res = bus.A & ~bus.B;
      3'b111: w_res = bus.A;
      default: w_res = '0;
    endcase
  end

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);
  assign w_ready = !w_full && !rst;
  assign w_push  = bus.in_valid && w_ready;
  assign w_pop   = !w_empty && bus.out_ready;

  // Storage holds no reset; only pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= '{
        n: w_res[WIDTH-1],
        z: (w_res == '0),
        c: w_res
      };
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rptr];

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = !w_empty;
  assign bus.occupancy = r_cnt;
  assign bus.C         = w_head.c;
  assign bus.Z         = w_head.z;
  assign bus.N         = w_head.n;
endmodule

// File: tb/tb_logic_result_stage.sv
// Self-checking bench for logic_result_stage: directed steps
// plus random traffic against a queue-based reference model.
module tb_logic_result_stage;
  logic clk;
  logic rst;
  int   errors;
  int   checks;
  bit   armed;

  logic [33:0] q[$];
  logic        prev_stall;
  logic [33:0] prev_out;

  logic_result_stage_if #(.WIDTH(32), .CW(2)) bus();

  logic_result_stage #(
    .WIDTH(32), .DEPTH(2), .CW(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [33:0] ref_res(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] o
  );
    logic [31:0] tbl [8];
    logic [31:0] r;
    tbl[0] = a & b;
    tbl[1] = ~(a & b);
    tbl[2] = a | b;
    tbl[3] = ~(a | b);
    tbl[4] = a ^ b;
    tbl[5] = ~(a ^ b);
    tbl[6] = a & ~b;
    tbl[7] = a;
    r = tbl[o];
    return {r[31], (r == 32'd0), r};
  endfunction

  task automatic chk(
    input string tag, input logic [33:0] got, input logic [33:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] dut_out();
    return {bus.N, bus.Z, bus.C};
  endfunction

  // One clock cycle: drive, check against model, clock, update model.
  task automatic cycle(
    input logic [31:0] a, input logic [31:0] b, input logic [2:0] o,
    input logic iv, input logic ordy, input logic r
  );
    logic push;
    logic pop;
    int   n;
    bus.A = a;
    bus.B = b;
    bus.op = o;
    bus.in_valid = iv;
    bus.out_ready = ordy;
    rst = r;
    #1;
    n = q.size();
    if (armed) begin
      chk("in_ready", 34'(bus.in_ready), 34'(!r && n < 2));
      chk("out_valid", 34'(bus.out_valid), 34'(n != 0));
      chk("occupancy", 34'(bus.occupancy), 34'(n));
      chk("head", dut_out(), (n != 0) ? q[0] : 34'd0);
      if (prev_stall) chk("stall_hold", dut_out(), prev_out);
    end
    prev_stall = !r && (n != 0) && !ordy;
    prev_out = dut_out();
    push = iv && !r && (n < 2);
    pop = !r && (n != 0) && ordy;
    @(posedge clk);
    if (r) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_res(a, b, o));
    end
    #1;
  endtask

  logic [31:0] sweep_exp [8];

  initial begin
    errors = 0;
    checks = 0;
    armed = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    rst = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.op = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    cycle(32'h1, 32'h2, 3'd0, 1'b1, 1'b0, 1'b1);
    armed = 1'b1;
    cycle(32'h1, 32'h2, 3'd0, 1'b1, 1'b0, 1'b1);
    chk("rst_occ", 34'(bus.occupancy), 34'd0);
    chk("rst_ovalid", 34'(bus.out_valid), 34'd0);

    // Single NAND op.
    cycle(32'hFFFF0000, 32'hFF00FF00, 3'd1, 1'b1, 1'b1, 1'b0);
    chk("nand_valid", 34'(bus.out_valid), 34'd1);
    chk("nand_res", dut_out(), {1'b0, 1'b0, 32'h00FFFFFF});
    cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
    chk("nand_drain", {bus.out_valid, dut_out()}, 35'd0);

    // Sweep all ops.
    sweep_exp[0] = 32'hF000F000;
    sweep_exp[1] = 32'h0FFF0FFF;
    sweep_exp[2] = 32'hFFF0FFF0;
    sweep_exp[3] = 32'h000F000F;
    sweep_exp[4] = 32'h0FF00FF0;
    sweep_exp[5] = 32'hF00FF00F;
    sweep_exp[6] = 32'h00F000F0;
    sweep_exp[7] = 32'hF0F0F0F0;
    for (int i = 0; i < 8; i++) begin
      cycle(32'hF0F0F0F0, 32'hFF00FF00, 3'(i), 1'b1, 1'b1, 1'b0);
      chk($sformatf("sweep_op%0d", i), 34'(bus.C), 34'(sweep_exp[i]));
    end
    cycle(32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 1'b1, 1'b1, 1'b0);
    chk("zero_flag", {bus.Z, bus.N, bus.C}, {1'b1, 1'b0, 32'd0});
    cycle(32'h80000000, 32'hFFFFFFFF, 3'd0, 1'b1, 1'b1, 1'b0);
    chk("neg_flag", {bus.Z, bus.N, bus.C}, {1'b0, 1'b1, 32'h80000000});
    cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Back-pressure with three XOR ops.
    cycle(32'd1, 32'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    cycle(32'd2, 32'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("bp_full_occ", 34'(bus.occupancy), 34'd2);
    chk("bp_full_rdy", 34'(bus.in_ready), 34'd0);
    cycle(32'd3, 32'd0, 3'd4, 1'b1, 1'b0, 1'b0);
    chk("bp_head1", 34'(bus.C), 34'd1);
    cycle(32'd3, 32'd0, 3'd4, 1'b1, 1'b1, 1'b0);
    chk("full_pop_occ", 34'(bus.occupancy), 34'd1);
    chk("bp_head2", 34'(bus.C), 34'd2);
    cycle(32'd3, 32'd0, 3'd4, 1'b1, 1'b1, 1'b0);
    chk("bp_head3", 34'(bus.C), 34'd3);
    cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
    cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Streaming at full rate.
    for (int i = 0; i < 100; i++) begin
      cycle($urandom, $urandom, 3'($urandom_range(7)), 1'b1, 1'b1, 1'b0);
      chk("stream_occ", 34'(bus.occupancy), 34'd1);
    end
    cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);

    // Random back-pressure.
    for (int i = 0; i < 1000; i++) begin
      cycle($urandom, $urandom, 3'($urandom_range(7)),
            1'($urandom_range(9) < 7), 1'($urandom_range(1)), 1'b0);
    end

    // Reset with a full buffer.
    cycle(32'hAAAA5555, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0);
    cycle(32'h5555AAAA, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0);
    cycle(32'h12345678, 32'h0, 3'd7, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_occ", 34'(bus.occupancy), 34'd2);
    cycle(32'hDEADBEEF, 32'h0, 3'd7, 1'b1, 1'b1, 1'b1);
    chk("post_rst", {bus.out_valid, bus.occupancy, dut_out()}, 37'd0);
    cycle(32'h0000CAFE, 32'h0, 3'd7, 1'b1, 1'b1, 1'b0);
    chk("post_rst_res", dut_out(), {1'b0, 1'b0, 32'h0000CAFE});
    for (int i = 0; i < 4; i++) begin
      cycle('0, '0, 3'd0, 1'b0, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_result_stage.md
Name: logic_result_stage

Overview:
- Registered result stage for the 32-bit bitwise logic unit.
- Accepts operand pairs A/B with a 3-bit op select through a valid/ready handshake and computes the bitwise result, including the NAND that the existing logic slice produces.
- Buffers result and flags in a small FIFO for the downstream writeback/flag stage. This decouples the logic unit from writeback stalls without dropping or duplicating results.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- DEPTH, 2, result-buffer entries; must be a power of 2 and ≥ 2.
- CW, 2, occupancy counter width; must equal log2(DEPTH)+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- op  input  3  operation select.
- in_valid  input  1  A/B/op valid this cycle.
- in_ready  output  1  stage can accept an operation.
- C  output  WIDTH  result at buffer head.
- Z  output  1  zero flag of head entry.
- N  output  1  sign flag of head entry (C[WIDTH-1]).
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream consumes head.
- occupancy  output  CW  number of buffered entries, 0..DEPTH.

Behaviour:
- Op encoding:
  - 000 AND.
  - 001 NAND.
  - 010 OR.
  - 011 NOR.
  - 100 XOR.
  - 101 XNOR.
  - 110 ANDN (A & ~B).
  - 111 PASS (A).
  - All codes are legal. The result is WIDTH bits; no carry, no overflow.
- Flags:
  - Z=1 iff the computed result == 0.
  - N = result[WIDTH-1].
  - Both are computed at accept time and stored with the entry.
- Accept: push occurs on a rising edge where in_valid && in_ready.
  - A, B and op are sampled only on that edge.
  - Input values while in_ready=0 are ignored.
- Pop: occurs on a rising edge where out_valid && out_ready.
- in_ready:
  - Equals (occupancy != DEPTH) && !rst.
  - Depends on registered state only; no combinational path from out_ready.
- out_valid:
  - Equals (occupancy != 0).
  - Registered path: an op accepted at edge k into an empty buffer gives out_valid=1 after edge k (latency 1 cycle).
- C/Z/N:
  - Show the head entry while out_valid=1.
  - Are forced to 0 while out_valid=0.
  - Hold stable while out_valid && !out_ready.
- FIFO order: strict; results leave in acceptance order.
- Simultaneous push and pop:
  - When 0 < occupancy < DEPTH, occupancy is unchanged and the head advances.
  - When full, no push occurs (in_ready=0); the pop alone reduces occupancy by 1, and in_ready rises after that edge.
  - When empty, no pop occurs; the push makes the entry visible next cycle (no bypass).
- Pointers: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH; occupancy never exceeds DEPTH and never goes below 0.
- Throughput: sustains 1 op/cycle with out_ready held at 1.
- Reset:
  - On an edge with rst=1, occupancy=0, pointers=0, out_valid=0, C=0, Z=0, N=0.
  - Buffered entries are discarded, including mid-stream.
  - in_ready=0 while rst is high and 1 on the first cycle after release.
  - in_valid is ignored during reset.
- Storage contents need no reset; only the pointers/occupancy do.

Test Plan:
- Reset, then op=001, A=32'hFFFF0000, B=32'hFF00FF00, one-cycle in_valid, out_ready=1 -> next cycle out_valid=1, C=32'h00FFFFFF, Z=0, N=0, then out_valid=0, C=0.
- Sweep all 8 ops with A=32'hF0F0F0F0, B=32'hFF00FF00 -> C=F000F000, 0FFF0FFF, FFF0FFF0, 000F000F, 0FF00FF0, F00FF00F, 00F000F0, F0F0F0F0; op=011 with A=B=32'hFFFFFFFF -> Z=1; op=000 giving 32'h80000000 -> N=1.
- out_ready=0, offer 3 ops (XOR results 1, 2, 3) -> first two accepted, occupancy=2, in_ready=0, third held; raise out_ready -> results 1, 2, 3 appear in order with no loss or duplicate.
- Full buffer, in_valid=1 and out_ready=1 on the same edge -> only the pop occurs, occupancy 2→1; the held op is accepted next edge; in steady state, 1 result per cycle for 100 random ops matching a reference model.
- Random out_ready back-pressure (50%) over 1000 random ops -> scoreboard match, C/Z/N stable while stalled, occupancy always within 0..2.
- Assert rst for 1 cycle with occupancy=2 -> after the edge out_valid=0, occupancy=0, C=0; in_ready=1 on the next cycle; pre-reset entries never appear.
